cf_spi_target: RTL and testbench

SPI target (slave) engine with TX/RX byte FIFOs, the bus-side peer of the team's SPI controller. It samples an external controller's `sclk`/`csb`/`mosi` through synchronizers in the system clock domain, shifts 8-bit bytes in on `mosi`, and drives queued response bytes out on `miso`. It supports all four CPOL/CPHA modes and uses the same FIFO status and threshold outputs as the controller, so the two share one register-wrapper style.

---
 rtl/cf_spi_pkg.sv | 11 +
 rtl/cf_spi_target_fifo.sv | 50 +++++
 rtl/cf_spi_target.sv | 208 ++++++++++++++++++++
 tb/tb_cf_spi_target.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cf_spi_pkg.sv
// Shared definitions for the SPI target engine: FSM encoding, synchronizer depth
// and byte width.
package cf_spi_pkg;
  localparam int SYNC_STAGES = 2;
  localparam int BYTE_W      = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;
endpackage

// File: rtl/cf_spi_target_fifo.sv
// Synchronous byte FIFO with flush; head is visible combinationally on dout.
module cf_spi_target_fifo
  import cf_spi_pkg::*;
#(
  parameter int FAW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  input  logic              pop,
  output logic [BYTE_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [FAW:0]      level
);
  localparam int DEPTH = 1 << FAW;

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [FAW:0]      r_wp;
  logic [FAW:0]      r_rp;
  logic              w_push;
  logic              w_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level  = r_wp - r_rp;
  assign empty  = (level == '0);
  assign full   = (level == (FAW+1)'(DEPTH));
  assign w_push = push && !full && !flush;
  assign w_pop  = pop && !empty && !flush;
  assign dout   = r_mem[r_rp[FAW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp[FAW-1:0]] <= din;
        r_wp                 <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
    end
  end
endmodule

// File: rtl/cf_spi_target.sv
// SPI target engine: synchronizes the external bus into clk, shifts bytes in on
// mosi / out on miso in any CPOL/CPHA mode, and buffers both directions in FIFOs.
module cf_spi_target
  import cf_spi_pkg::*;
#(
  parameter int         FAW       = 4,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           CPOL,
  input  logic           CPHA,
  input  logic           wr,
  input  logic [7:0]     datai,
  input  logic           rd,
  output logic [7:0]     datao,
  input  logic           rx_en,
  input  logic           rx_flush,
  input  logic           tx_flush,
  input  logic [FAW-1:0] rx_threshold,
  input  logic [FAW-1:0] tx_threshold,
  output logic           rx_empty,
  output logic           rx_full,
  output logic           tx_empty,
  output logic           tx_full,
  output logic [FAW:0]   rx_level,
  output logic [FAW:0]   tx_level,
  output logic           rx_level_above,
  output logic           tx_level_below,
  output logic           busy,
  output logic           done,
  output logic           rx_overrun,
  output logic           tx_underrun,
  input  logic           sclk,
  input  logic           csb,
  input  logic           mosi,
  output logic           miso,
  output logic           miso_oe
);
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_csb_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_p2;
  logic                   r_csb_p2;
  logic                   w_sclk;
  logic                   w_csb;
  logic                   w_mosi;
  logic                   w_lead;
  logic                   w_trail;
  logic                   w_csb_fall;
  logic                   w_csb_rise;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_enter;
  logic                   w_run;
  logic                   w_sample;
  logic                   w_wrap;
  logic                   w_boundary;
  logic                   w_shift;
  logic                   w_load;
  logic [7:0]             w_tx_head;
  logic [7:0]             w_tx_byte;
  logic                   w_rx_push;

  logic [2:0]             r_cnt;
  logic [6:0]             r_rx_sh;
  logic [7:0]             r_rx_byte;
  logic [7:0]             r_tx_sh;
  logic                   r_wrap_pend;
  logic                   r_done;
  logic                   r_tx_underrun;
  logic                   r_miso;

  // Synchronizer stages plus one edge-detect register, reset to the idle bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= {SYNC_STAGES{CPOL}};
      r_csb_sync  <= '1;
      r_mosi_sync <= '0;
      r_sclk_p2   <= CPOL;
      r_csb_p2    <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0], csb};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_p2   <= w_sclk;
      r_csb_p2    <= w_csb;
    end
  end

  assign w_sclk     = r_sclk_sync[SYNC_STAGES-1];
  assign w_csb      = r_csb_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_lead     = (r_sclk_p2 == CPOL) && (w_sclk != CPOL);
  assign w_trail    = (r_sclk_p2 != CPOL) && (w_sclk == CPOL);
  assign w_csb_fall = r_csb_p2 && !w_csb;
  assign w_csb_rise = !r_csb_p2 && w_csb;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_csb_fall && enable) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (w_csb_rise || !enable) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state == ST_ACTIVE);
    miso_oe = (r_state == ST_ACTIVE);
  end

  // CPHA=0 samples on the leading edge, so its byte boundary is the trailing edge
  // that follows the counter wrap; CPHA=1 wraps and reloads on the same edge.
  assign w_enter    = (r_state == ST_IDLE) && (w_state_nxt == ST_ACTIVE);
  assign w_run      = (r_state == ST_ACTIVE) && (w_state_nxt == ST_ACTIVE);
  assign w_sample   = w_run && (CPHA ? w_trail : w_lead);
  assign w_wrap     = w_sample && (r_cnt == 3'd7);
  assign w_boundary = w_run && (CPHA ? w_wrap : (w_trail && r_wrap_pend));
  assign w_shift    = w_run && (CPHA ? w_lead : (w_trail && !r_wrap_pend));
  assign w_load     = w_enter || w_boundary;
  assign w_tx_byte  = tx_empty ? IDLE_BYTE : w_tx_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_rx_sh       <= '0;
      r_rx_byte     <= '0;
      r_tx_sh       <= '0;
      r_wrap_pend   <= 1'b0;
      r_done        <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_miso        <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_tx_underrun <= w_load && tx_empty;
      if (!w_run) begin
        r_cnt       <= '0;
        r_rx_sh     <= '0;
        r_wrap_pend <= 1'b0;
      end else begin
        if (w_sample) begin
          r_cnt   <= r_cnt + 3'd1;
          r_rx_sh <= {r_rx_sh[5:0], w_mosi};
        end
        if (w_wrap) begin
          r_rx_byte <= {r_rx_sh, w_mosi};
          r_done    <= 1'b1;
        end
        if (w_wrap && !CPHA)  r_wrap_pend <= 1'b1;
        else if (w_boundary)  r_wrap_pend <= 1'b0;
      end
      if (w_load) begin
        if (CPHA) begin
          r_tx_sh <= w_tx_byte;
        end else begin
          r_miso  <= w_tx_byte[7];
          r_tx_sh <= {w_tx_byte[6:0], 1'b0};
        end
      end else if (w_shift) begin
        r_miso  <= r_tx_sh[7];
        r_tx_sh <= {r_tx_sh[6:0], 1'b0};
      end
    end
  end

  assign miso        = r_miso;
  assign done        = r_done;
  assign tx_underrun = r_tx_underrun;
  assign w_rx_push   = r_done && rx_en && !rx_full;
  assign rx_overrun  = r_done && rx_en && rx_full;

  assign rx_level_above = (rx_level > {1'b0, rx_threshold});
  assign tx_level_below = (tx_level < {1'b0, tx_threshold});

  cf_spi_target_fifo #(.FAW(FAW)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (rx_flush),
    .push  (w_rx_push),
    .din   (r_rx_byte),
    .pop   (rd),
    .dout  (datao),
    .empty (rx_empty),
    .full  (rx_full),
    .level (rx_level)
  );

  cf_spi_target_fifo #(.FAW(FAW)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (tx_flush),
    .push  (wr),
    .din   (datai),
    .pop   (w_load && !tx_empty),
    .dout  (w_tx_head),
    .empty (tx_empty),
    .full  (tx_full),
    .level (tx_level)
  );
endmodule

// File: tb/tb_cf_spi_target.sv
// Directed bench for cf_spi_target: a bit-banged SPI controller drives the bus
// and every scenario checks its own hand-computed results.
module tb_cf_spi_target;
  localparam int FAW = 2;

  logic           clk = 1'b0;
  logic           rst, enable, CPOL, CPHA, wr, rd, rx_en, rx_flush, tx_flush;
  logic [7:0]     datai, datao;
  logic [FAW-1:0] rx_threshold, tx_threshold;
  logic           rx_empty, rx_full, tx_empty, tx_full;
  logic [FAW:0]   rx_level, tx_level;
  logic           rx_level_above, tx_level_below, busy, done, rx_overrun, tx_underrun;
  logic           sclk, csb, mosi, miso, miso_oe;

  int checks = 0;
  int errors = 0;
  int n_done = 0, n_over = 0, n_under = 0, n_under_pre = 0;

  always #5 clk = ~clk;

  cf_spi_target #(.FAW(FAW), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .rst(rst), .enable(enable), .CPOL(CPOL), .CPHA(CPHA),
    .wr(wr), .datai(datai), .rd(rd), .datao(datao), .rx_en(rx_en),
    .rx_flush(rx_flush), .tx_flush(tx_flush),
    .rx_threshold(rx_threshold), .tx_threshold(tx_threshold),
    .rx_empty(rx_empty), .rx_full(rx_full), .tx_empty(tx_empty), .tx_full(tx_full),
    .rx_level(rx_level), .tx_level(tx_level),
    .rx_level_above(rx_level_above), .tx_level_below(tx_level_below),
    .busy(busy), .done(done), .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
    .sclk(sclk), .csb(csb), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
  );

  // Pulse counters; n_under_pre only counts underruns seen before the first done.
  always @(negedge clk) begin
    if (done) n_done++;
    if (rx_overrun) n_over++;
    if (tx_underrun) begin
      n_under++;
      if (n_done == 0) n_under_pre++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic zero_counts();
    n_done = 0; n_over = 0; n_under = 0; n_under_pre = 0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk);
    CPOL = m[1]; CPHA = m[0]; sclk = m[1];
    repeat (6) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    wr = 1'b1; datai = b;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic pop(output logic [7:0] b);
    @(negedge clk);
    b  = datao;
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic frame_start();
    @(negedge clk);
    csb = 1'b0;
    half();
  endtask

  task automatic frame_end();
    half();
    csb = 1'b1;
    half();
  endtask

  // Controller side of one byte, MSB first; nbits < 8 gives a truncated byte.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!CPHA) begin
        mosi = tx[i]; half();
        sclk = ~CPOL; rx[i] = miso; half();
        sclk = CPOL;
      end else begin
        sclk = ~CPOL; mosi = tx[i]; half();
        sclk = CPOL; rx[i] = miso; half();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; CPOL = 1'b0; CPHA = 1'b0; wr = 1'b0; rd = 1'b0;
    datai = '0; rx_en = 1'b1; rx_flush = 1'b0; tx_flush = 1'b0;
    rx_threshold = 2'd1; tx_threshold = 2'd2;
    sclk = 1'b0; csb = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({miso, miso_oe, busy, done, rx_overrun, tx_underrun} !== 6'b0) begin
      errors++;
      $display("FAIL reset_pulses: {miso,oe,busy,done,ovr,und}=%b required 000000",
               {miso, miso_oe, busy, done, rx_overrun, tx_underrun});
    end
    checks++;
    if ({rx_empty, tx_empty, rx_full, tx_full} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_flags: {rxe,txe,rxf,txf}=%b required 1100",
               {rx_empty, tx_empty, rx_full, tx_full});
    end
    checks++;
    if (rx_level !== 3'd0 || tx_level !== 3'd0) begin
      errors++;
      $display("FAIL reset_levels: rx=%0d tx=%0d required 0 0", rx_level, tx_level);
    end
    checks++;
    if (datao !== 8'h00) begin
      errors++;
      $display("FAIL reset_datao: %h required 00", datao);
    end
    checks++;
    if ({rx_level_above, tx_level_below} !== 2'b01) begin
      errors++;
      $display("FAIL reset_thresholds: {above,below}=%b required 01",
               {rx_level_above, tx_level_below});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mode0_single();
    logic [7:0] rx;
    logic [7:0] b;
    set_mode(2'b00);
    zero_counts();
    push(8'hA5);
    frame_start();
    checks++;
    if (busy !== 1'b1 || miso_oe !== 1'b1) begin
      errors++;
      $display("FAIL m0_busy: busy=%b oe=%b required 1 1", busy, miso_oe);
    end
    xfer(8'h3C, 8, rx);
    frame_end();
    checks++;
    if (rx !== 8'hA5) begin
      errors++;
      $display("FAIL m0_miso: got %h required a5", rx);
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL m0_done: %0d pulses required 1", n_done);
    end
    checks++;
    if (rx_level !== 3'd1 || datao !== 8'h3C) begin
      errors++;
      $display("FAIL m0_rx: level=%0d datao=%h required 1 3c", rx_level, datao);
    end
    pop(b);
  endtask

  task automatic test_modes();
    logic [7:0] snd [4];
    logic [7:0] ret [4];
    logic [7:0] rx;
    logic [7:0] b;
    snd = '{8'h01, 8'h80, 8'hFF, 8'h00};
    ret = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int m = 0; m < 4; m++) begin
      set_mode(m[1:0]);
      zero_counts();
      for (int k = 0; k < 4; k++) push(ret[k]);
      checks++;
      if (tx_full !== 1'b1 || tx_level_below !== 1'b0) begin
        errors++;
        $display("FAIL mode%0d_txfull: full=%b below=%b required 1 0", m, tx_full, tx_level_below);
      end
      frame_start();
      for (int k = 0; k < 4; k++) begin
        xfer(snd[k], 8, rx);
        checks++;
        if (rx !== ret[k]) begin
          errors++;
          $display("FAIL mode%0d_byte%0d: got %h required %h", m, k, rx, ret[k]);
        end
      end
      frame_end();
      checks++;
      if (n_done != 4 || tx_empty !== 1'b1) begin
        errors++;
        $display("FAIL mode%0d_end: done=%0d tx_empty=%b required 4 1", m, n_done, tx_empty);
      end
      checks++;
      if (rx_level !== 3'd4 || rx_full !== 1'b1 || rx_level_above !== 1'b1) begin
        errors++;
        $display("FAIL mode%0d_rxlvl: level=%0d full=%b above=%b required 4 1 1",
                 m, rx_level, rx_full, rx_level_above);
      end
      for (int k = 0; k < 4; k++) begin
        pop(b);
        checks++;
        if (b !== snd[k]) begin
          errors++;
          $display("FAIL mode%0d_rx%0d: got %h required %h", m, k, b, snd[k]);
        end
      end
    end
    set_mode(2'b00);
  endtask

  task automatic test_underrun();
    logic [7:0] rx;
    logic [7:0] b;
    zero_counts();
    frame_start();
    xfer(8'h5A, 8, rx);
    frame_end();
    checks++;
    if (rx !== 8'hFF) begin
      errors++;
      $display("FAIL underrun_idle: got %h required ff", rx);
    end
    checks++;
    if (n_under_pre != 1) begin
      errors++;
      $display("FAIL underrun_pulse: %0d pulses required 1", n_under_pre);
    end
    pop(b);
    checks++;
    if (b !== 8'h5A) begin
      errors++;
      $display("FAIL underrun_rx: got %h required 5a", b);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] fill [4];
    logic [7:0] rx;
    logic [7:0] b;
    fill = '{8'h10, 8'h20, 8'h30, 8'h40};
    zero_counts();
    frame_start();
    for (int k = 0; k < 4; k++) xfer(fill[k], 8, rx);
    frame_end();
    checks++;
    if (rx_full !== 1'b1 || n_over != 0) begin
      errors++;
      $display("FAIL overrun_fill: full=%b ovr=%0d required 1 0", rx_full, n_over);
    end
    frame_start();
    xfer(8'h99, 8, rx);
    frame_end();
    checks++;
    if (n_over != 1 || n_done != 5) begin
      errors++;
      $display("FAIL overrun_pulse: ovr=%0d done=%0d required 1 5", n_over, n_done);
    end
    checks++;
    if (rx_full !== 1'b1 || rx_level !== 3'd4) begin
      errors++;
      $display("FAIL overrun_level: full=%b level=%0d required 1 4", rx_full, rx_level);
    end
    for (int k = 0; k < 4; k++) begin
      pop(b);
      checks++;
      if (b !== fill[k]) begin
        errors++;
        $display("FAIL overrun_data%0d: got %h required %h", k, b, fill[k]);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    int t;
    zero_counts();
    push(8'h77);
    frame_start();
    xfer(8'hE7, 5, rx);
    @(negedge clk);
    csb = 1'b1;
    t = 0;
    while (busy && t < 8) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (busy !== 1'b0 || t > 4) begin
      errors++;
      $display("FAIL abort_busy: busy=%b after %0d clk required 0 within 4", busy, t);
    end
    half();
    checks++;
    if (n_done != 0 || rx_level !== 3'd0 || tx_empty !== 1'b1) begin
      errors++;
      $display("FAIL abort_state: done=%0d rx_level=%0d tx_empty=%b required 0 0 1",
               n_done, rx_level, tx_empty);
    end
    push(8'h6E);
    frame_start();
    xfer(8'hC3, 8, rx);
    frame_end();
    checks++;
    if (rx !== 8'h6E || n_done != 1) begin
      errors++;
      $display("FAIL abort_next_tx: got %h done=%0d required 6e 1", rx, n_done);
    end
    checks++;
    if (datao !== 8'hC3 || rx_level !== 3'd1) begin
      errors++;
      $display("FAIL abort_next_rx: datao=%h level=%0d required c3 1", datao, rx_level);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    logic [7:0] b;
    push(8'h5D);
    push(8'h3A);
    frame_start();
    xfer(8'hAA, 4, rx);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({miso, miso_oe, busy, done, rx_overrun, tx_underrun} !== 6'b0) begin
      errors++;
      $display("FAIL rstmid_pulses: {miso,oe,busy,done,ovr,und}=%b required 000000",
               {miso, miso_oe, busy, done, rx_overrun, tx_underrun});
    end
    checks++;
    if ({rx_empty, tx_empty} !== 2'b11 || rx_level !== 3'd0 || tx_level !== 3'd0 || datao !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_fifos: rxe=%b txe=%b rxl=%0d txl=%0d datao=%h required 1 1 0 0 00",
               rx_empty, tx_empty, rx_level, tx_level, datao);
    end
    csb = 1'b1; sclk = CPOL;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    zero_counts();
    push(8'hC6);
    frame_start();
    xfer(8'h39, 8, rx);
    frame_end();
    checks++;
    if (rx !== 8'hC6) begin
      errors++;
      $display("FAIL rstmid_tx: got %h required c6", rx);
    end
    pop(b);
    checks++;
    if (b !== 8'h39 || n_done != 1) begin
      errors++;
      $display("FAIL rstmid_rx: got %h done=%0d required 39 1", b, n_done);
    end
  endtask

  initial begin
    test_reset();
    test_mode0_single();
    test_modes();
    test_underrun();
    test_overrun();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
